// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared fetch types, IF/ID register layout and bubble constant
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic {RUN, HALTED} fetch_state_t;
  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
    logic  valid;
  } ifid_t;
  localparam word_t NOP_INSTR = 32'h0;
  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, npc: 32'h0, valid: 1'b0};
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: I-cache request, hazard control and IF/ID outputs of the fetch stage
interface fetch_stage_if;
  import cpu_types_pkg::*;
  logic  ihit;
  word_t iload;
  logic  imemREN;
  word_t imemaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t ifid_instr;
  word_t ifid_pc;
  word_t ifid_npc;
  logic  ifid_valid;
  modport master (
    input  ihit, iload, stall, redirect, redirect_pc, halt,
    output imemREN, imemaddr, ifid_instr, ifid_pc, ifid_npc, ifid_valid
  );
  modport slave (
    output ihit, iload, stall, redirect, redirect_pc, halt,
    input  imemREN, imemaddr, ifid_instr, ifid_pc, ifid_npc, ifid_valid
  );
endinterface

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer holding a fetch that returned while decode was stalled
module fetch_skid
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  push,
  input  logic  pop,
  input  logic  clear,
  input  ifid_t din,
  output logic  full,
  output ifid_t dout
);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      full <= 1'b0;
      dout <= BUBBLE;
    end else if (clear) begin
      full <= 1'b0;
      dout <= BUBBLE;
    end else if (push) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, I-cache request and IF/ID register with stall/redirect/halt.
// Define FETCH_SKID_EN to keep a fetch that returns during a stall instead of refetching it.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input logic CLK,
  input logic nRST,
  fetch_stage_if.master f
);
  fetch_state_t state_q, state_d;
  word_t pc_q, pc_d, pc_inc;
  ifid_t ifid_q, ifid_d, fetched, skid_q;
  logic run, hit, skid_full, push;
  assign run     = state_q == RUN;
  assign pc_inc  = pc_q + 32'd4;
  assign fetched = '{instr: f.iload, pc: pc_q, npc: pc_inc, valid: 1'b1};
  assign hit     = f.ihit & f.imemREN;
`ifdef FETCH_SKID_EN
  logic pop, clear;
  assign push  = run & !f.redirect & f.stall & hit;
  assign pop   = run & !f.redirect & !f.stall & !f.halt & skid_full;
  assign clear = run & (f.redirect | (!f.stall & f.halt));
  fetch_skid u_skid (
    .CLK   (CLK),
    .nRST  (nRST),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (fetched),
    .full  (skid_full),
    .dout  (skid_q)
  );
`else
  assign push      = 1'b0;
  assign skid_full = 1'b0;
  assign skid_q    = BUBBLE;
`endif
  assign f.imemREN    = run & !skid_full;
  assign f.imemaddr   = pc_q;
  assign f.ifid_instr = ifid_q.instr;
  assign f.ifid_pc    = ifid_q.pc;
  assign f.ifid_npc   = ifid_q.npc;
  assign f.ifid_valid = ifid_q.valid;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT;
      ifid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end
  // redirect > stall > halt > (skid drain | ihit); HALTED leaves only the bubble default
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = BUBBLE;
    if (run) begin
      if (f.redirect) begin
        pc_d = f.redirect_pc;
      end else if (f.stall) begin
        ifid_d = ifid_q;
        pc_d   = push ? pc_inc : pc_q;
      end else if (f.halt) begin
        state_d = HALTED;
      end else if (skid_full) begin
        ifid_d = skid_q;
      end else if (hit) begin
        ifid_d = fetched;
        pc_d   = pc_inc;
      end
    end
  end
endmodule
